conv_controller: RTL and testbench
==================================

# conv_controller

Sequencer for one `convolver` instance (params n, k, s, N).
- Loads the k*k kernel weights from a serial weight stream into the packed `weight1` bus.
- Clears the convolver, then streams the n*n activation map from a synchronous-read buffer.
- Captures every valid convolution result into an output buffer.
- Reports completion with a start/busy/done handshake.

Sits between the layer-level scheduler and the convolver datapath.

## Interface

Parameters:
- n, 10: activation map size (n x n)
- k, 3: kernel size
- s, 1: stride, forwarded convention only; affects expected output count
- N, 16: data width
- ADDR_W, 16: buffer address width; must hold n*n-1
- DRAIN_MAX, 2*n+8: max drain cycles before timeout

Ports:
- clk, in, 1: clock
- global_rst_n, in, 1: reset, asynchronous, active-low
- start, in, 1: begin one convolution pass (sampled in IDLE only)
- busy, out, 1: high in any state other than IDLE
- done, out, 1: one-cycle pulse at pass end
- err, out, 1: drain timeout flag, sticky until next start
- wt_data, in, N: weight beat
- wt_valid, in, 1: weight beat valid
- wt_ready, out, 1: high in LOAD_W
- act_rd_en, out, 1: activation buffer read strobe
- act_addr, out, ADDR_W: activation read address
- act_data, in, N: read data, valid one cycle after act_rd_en
- weight1, out, k*k*N: packed weights to convolver, beat i at [N*i +: N]
- conv_rst, out, 1: synchronous clear to convolver, active-high
- conv_ce, out, 1: convolver clock enable
- conv_activation, out, N: activation to convolver
- conv_op, in, N: convolver result
- valid_conv, in, 1: convolver result valid
- out_we, out, 1: output buffer write strobe
- out_addr, out, ADDR_W: output write address
- out_data, out, N: output write data

## Operation

- O_TOTAL = ((n-k)/s+1)^2, using integer division.

States:

- IDLE
  - wt_ready=0.
  - start=1 → LOAD_W; wcnt=0, out_cnt=0, err=0.
- LOAD_W
  - wt_ready=1.
  - Each wt_valid&&wt_ready writes weight1 slot wcnt, then wcnt++.
  - Beat k*k-1 accepted → CLEAR.
- CLEAR
  - conv_rst=1 for exactly 2 cycles, conv_ce=0, then → STREAM with act_addr=0.
- STREAM
  - act_rd_en=1 every cycle; act_addr increments 0..n*n-1.
  - Cycle issuing addr n*n-1 → DRAIN.
- DRAIN
  - act_rd_en=0; conv_ce stays 1 with conv_activation=0 to flush the MAC pipeline.
  - Exit → DONE when out_cnt reaches O_TOTAL.
  - Exit → DONE with err=1 when DRAIN has lasted DRAIN_MAX cycles.
- DONE
  - done=1 for one cycle → IDLE.

Datapath rules:
- conv_ce is the registered act_rd_en during STREAM, and 1 during DRAIN; 0 in all other states.
- conv_activation = act_data when the delayed read strobe is high, else 0.
- valid_conv is accepted only in STREAM/DRAIN with out_cnt < O_TOTAL.
  - On acceptance, register out_we=1, out_data=conv_op, out_addr=out_cnt; out_cnt++.
  - Excess valids are dropped.
- weight1 holds its value after DONE until the next LOAD_W overwrites it.
- start outside IDLE is ignored.

## Timing

Reset values (global_rst_n=0, takes effect immediately):
- State IDLE.
- busy, done, err, wt_ready, act_rd_en, conv_ce, out_we = 0.
- act_addr, out_addr, out_data, conv_activation, weight1 = 0.
- conv_rst = 1 while reset is asserted.

Cycle relationships:
- start→busy: 1 cycle.
- Weight load: k*k cycles with no gaps; bubbles in wt_valid extend it 1:1.
- act_rd_en at cycle t with address a → conv_ce=1 and conv_activation=mem[a] at t+1.
- Exactly n*n conv_ce cycles carry real data.
- valid_conv at t → out_we at t+1.
- done asserts the cycle after the final out_we, or the cycle after timeout.

Boundary cases:
- Reset during any state aborts the pass: no done pulse, and the output buffer contents are undefined.
- start held high across DONE→IDLE begins a new pass on the IDLE cycle.

## Test plan

- Weight load with gaps: n=5, k=3; 9 beats 1..9 with wt_valid low every other cycle → weight1 slot i = i+1; CLEAR begins after the 9th accept; wt_ready is 0 otherwise.
- Full pass, all-ones weights: n=5, k=3, s=1, activation map all 1.0 (Q12) → exactly 9 out_we at addresses 0..8, each out_data = 9.0, then a single done pulse, err=0.
- Ramp-map check: n=10, k=3, identity-centre kernel, map value = address → 64 outputs; out_data[r*8+c] = act at (r+1, c+1).
- start while busy: pulse start during STREAM → no state change, and the pass completes normally with 9 outputs (n=5).
- Timeout: tie valid_conv=0 → DRAIN lasts DRAIN_MAX cycles, then err=1, done pulse, out_we never asserted.
- Async reset mid-STREAM at act_addr=12 → all outputs at reset values immediately; a following start runs a clean full pass.

Source files
------------

// File: rtl/conv_controller.sv
// conv_controller: sequences one convolver pass. Loads the kernel from a
// serial weight stream, clears the convolver, streams the activation map out
// of a synchronous-read buffer, flushes the MAC pipeline, and writes every
// accepted convolution result into the output buffer.
module conv_controller #(
  parameter int n         = 10,
  parameter int k         = 3,
  parameter int s         = 1,
  parameter int N         = 16,
  parameter int ADDR_W    = 16,
  parameter int DRAIN_MAX = 2*n+8
) (
  input  logic              clk,
  input  logic              global_rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [N-1:0]      wt_data,
  input  logic              wt_valid,
  output logic              wt_ready,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_addr,
  input  logic [N-1:0]      act_data,
  output logic [k*k*N-1:0]  weight1,
  output logic              conv_rst,
  output logic              conv_ce,
  output logic [N-1:0]      conv_activation,
  input  logic [N-1:0]      conv_op,
  input  logic              valid_conv,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [N-1:0]      out_data
);

  localparam int KK      = k*k;
  localparam int NN      = n*n;
  localparam int O_SIDE  = (n-k)/s + 1;
  localparam int O_TOTAL = O_SIDE*O_SIDE;
  localparam int WC_W    = (KK > 1) ? $clog2(KK + 1) : 1;
  localparam int OC_W    = $clog2(O_TOTAL + 1);
  localparam int DC_W    = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  localparam logic [WC_W-1:0]   WC_LAST    = WC_W'(KK-1);
  localparam logic [WC_W-1:0]   WC_ONE     = WC_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NN-1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [OC_W-1:0]   O_TOTAL_C  = OC_W'(O_TOTAL);
  localparam logic [OC_W-1:0]   OC_ONE     = OC_W'(1);
  localparam logic [DC_W-1:0]   DRAIN_LAST = DC_W'(DRAIN_MAX-1);
  localparam logic [DC_W-1:0]   DC_ONE     = DC_W'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_W = 3'd1;
  localparam logic [2:0] CLEAR  = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_next;
  logic [WC_W-1:0] wcnt;
  logic            clr_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic [OC_W-1:0] out_cnt;
  logic            rd_d;
  logic            wt_accept;
  logic            out_accept;
  logic            drain_timeout;
  logic            pass_start;

  // The buffer returns data one cycle after the strobe, which is exactly the
  // cycle conv_ce rises, so the activation is gated straight from act_data.
  assign conv_activation = rd_d ? act_data : {N{1'b0}};

  // Next-state decode and the per-cycle handshake qualifiers.
  always_comb begin
    state_next    = state;
    wt_accept     = wt_valid && wt_ready;
    pass_start    = (state == IDLE) && start;
    drain_timeout = 1'b0;
    if (((state == STREAM) || (state == DRAIN)) && (out_cnt < O_TOTAL_C)) begin
      out_accept = valid_conv;
    end else begin
      out_accept = 1'b0;
    end
    case (state)
      IDLE: begin
        if (start) state_next = LOAD_W;
        else       state_next = IDLE;
      end
      LOAD_W: begin
        if (wt_accept && (wcnt == WC_LAST)) state_next = CLEAR;
        else                                state_next = LOAD_W;
      end
      CLEAR: begin
        if (clr_cnt) state_next = STREAM;
        else         state_next = CLEAR;
      end
      STREAM: begin
        if (act_addr == ADDR_LAST) state_next = DRAIN;
        else                       state_next = STREAM;
      end
      DRAIN: begin
        // A completed pass wins over a timeout landing on the same cycle.
        if (out_cnt == O_TOTAL_C) begin
          state_next = DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_next    = DONE;
          drain_timeout = 1'b1;
        end else begin
          state_next = DRAIN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, counters and the registered control outputs.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wt_ready  <= 1'b0;
      conv_rst  <= 1'b1;
      act_rd_en <= 1'b0;
      rd_d      <= 1'b0;
      conv_ce   <= 1'b0;
      wcnt      <= {WC_W{1'b0}};
      clr_cnt   <= 1'b0;
      drain_cnt <= {DC_W{1'b0}};
      act_addr  <= {ADDR_W{1'b0}};
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      wt_ready  <= (state_next == LOAD_W);
      conv_rst  <= (state_next == CLEAR);
      act_rd_en <= (state_next == STREAM);
      rd_d      <= act_rd_en;
      conv_ce   <= (state_next == DRAIN) || ((state_next == STREAM) && act_rd_en);
      clr_cnt   <= (state == CLEAR) ? ~clr_cnt : 1'b0;
      drain_cnt <= (state == DRAIN) ? (drain_cnt + DC_ONE) : {DC_W{1'b0}};
      if (pass_start) begin
        wcnt <= {WC_W{1'b0}};
      end else if (wt_accept) begin
        wcnt <= wcnt + WC_ONE;
      end
      if (pass_start) begin
        err <= 1'b0;
      end else if (drain_timeout) begin
        err <= 1'b1;
      end
      // Address parks on the last pixel once streaming ends.
      if (state == CLEAR) begin
        act_addr <= {ADDR_W{1'b0}};
      end else if ((state == STREAM) && (act_addr != ADDR_LAST)) begin
        act_addr <= act_addr + ADDR_ONE;
      end
    end
  end

  // Kernel register: each accepted beat lands in the slot named by wcnt and
  // the whole bus holds until the next load overwrites it.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      weight1 <= {(KK*N){1'b0}};
    end else begin
      for (int i = 0; i < KK; i++) begin
        if (wt_accept && (wcnt == WC_W'(i))) weight1[N*i +: N] <= wt_data;
      end
    end
  end

  // Result capture: registers one output-buffer write per accepted valid and
  // silently drops anything beyond the expected output count.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      out_cnt  <= {OC_W{1'b0}};
      out_we   <= 1'b0;
      out_addr <= {ADDR_W{1'b0}};
      out_data <= {N{1'b0}};
    end else begin
      out_we <= out_accept;
      if (pass_start) begin
        out_cnt <= {OC_W{1'b0}};
      end else if (out_accept) begin
        out_cnt  <= out_cnt + OC_ONE;
        out_addr <= ADDR_W'(out_cnt);
        out_data <= conv_op;
      end
    end
  end

endmodule

// File: tb/tb_conv_controller.sv
// tb_conv_controller: directed pass sequence with randomized weights/maps.
// A small convolver stand-in reacts to conv_rst/conv_ce/conv_activation and
// weight1; results are compared against a convolution computed directly from
// the bench's own map and kernel arrays.
module tb_conv_controller;

  localparam int n         = 5;
  localparam int k         = 3;
  localparam int s         = 1;
  localparam int N         = 16;
  localparam int ADDR_W    = 16;
  localparam int DRAIN_MAX = 2*n+8;
  localparam int KK        = k*k;
  localparam int NN        = n*n;
  localparam int OS        = (n-k)/s + 1;
  localparam int OT        = OS*OS;

  logic              clk = 1'b0;
  logic              global_rst_n;
  logic              start;
  logic              busy, done, err;
  logic [N-1:0]      wt_data;
  logic              wt_valid, wt_ready;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic [N-1:0]      act_data;
  logic [KK*N-1:0]   weight1;
  logic              conv_rst, conv_ce;
  logic [N-1:0]      conv_activation, conv_op;
  logic              valid_conv, out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [N-1:0]      out_data;

  conv_controller #(.n(n), .k(k), .s(s), .N(N), .ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data), .weight1(weight1),
    .conv_rst(conv_rst), .conv_ce(conv_ce), .conv_activation(conv_activation),
    .conv_op(conv_op), .valid_conv(valid_conv),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [N-1:0] val; } pend_t;

  int             n_assert = 0;
  int             n_fail = 0;
  int unsigned    mem[NN];
  int unsigned    wts[KK];
  int unsigned    rx[$];
  pend_t          pq[$];
  int             cyc = 0;
  bit             mock_on, extra_on;
  int             mock_lat;
  bit             rd_pend;
  int             rd_addr_pend;
  int             cap_addr[$];
  logic [N-1:0]   cap_data[$];
  int             done_cnt, done_cyc, last_we_cyc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain window convolution in Q12: sum of products, then drop 12 fraction bits.
  function automatic logic [N-1:0] conv_at(input int unsigned w[KK], input int unsigned img[NN],
                                           input int r0, input int c0);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        acc += longint'(w[i*k+j]) * longint'(img[(r0+i)*n + c0 + j]);
    return N'(acc >> 12);
  endfunction

  // One clock: buffer read model, output capture, convolver stand-in.
  task automatic tick();
    int p, r, c;
    int unsigned img[NN];
    int unsigned wv[KK];
    pend_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend && rd_addr_pend < NN) act_data = N'(mem[rd_addr_pend]);
    else                              act_data = N'($urandom);
    rd_pend      = (act_rd_en === 1'b1);
    rd_addr_pend = int'(act_addr);
    if (out_we === 1'b1) begin
      cap_addr.push_back(int'(out_addr));
      cap_data.push_back(out_data);
      last_we_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    #1;
    if (conv_rst === 1'b1) begin
      rx.delete();
    end else if (conv_ce === 1'b1) begin
      rx.push_back(int'(conv_activation));
      p = rx.size() - 1;
      r = p / n;
      c = p % n;
      if (mock_on && p < NN && r >= k-1 && c >= k-1 && ((r-k+1) % s) == 0 && ((c-k+1) % s) == 0) begin
        for (int i = 0; i < NN; i++) img[i] = (i < rx.size()) ? rx[i] : 0;
        for (int i = 0; i < KK; i++) wv[i] = int'(weight1[N*i +: N]);
        e.due = cyc + mock_lat;
        e.val = conv_at(wv, img, r-k+1, c-k+1);
        pq.push_back(e);
        if (extra_on && p == NN-1) begin
          e.due = cyc + mock_lat + 1;
          e.val = N'($urandom);
          pq.push_back(e);
        end
      end
    end
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      valid_conv = 1'b1;
      conv_op    = pq[0].val;
      void'(pq.pop_front());
    end else begin
      valid_conv = 1'b0;
      conv_op    = N'($urandom);
    end
  endtask

  task automatic run_pass(input bit gaps, input bit mid_start, input bit mock_en, input int rst_at,
                          input bit extra, input bit hold_start, input bit started);
    int b, guard, dcount;
    bit ok;
    logic [KK*N-1:0] wexp;
    logic [N-1:0] ev;
    mock_on  = mock_en;
    extra_on = extra;
    mock_lat = $urandom_range(3, 1);
    cap_addr.delete();
    cap_data.delete();
    done_cnt = 0; done_cyc = -1; last_we_cyc = -1;
    for (int i = 0; i < KK; i++) wexp[N*i +: N] = N'(wts[i]);
    if (!started) begin
      chk("idle_wt_ready", wt_ready, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("start_busy", busy, 1);
    chk("load_wt_ready", wt_ready, 1);
    chk("start_err_clear", err, 0);
    // Weight load, optionally with wt_valid low every other cycle.
    b = 0; guard = 0; ok = 1;
    while (b < KK && guard < 100) begin
      guard++;
      if (gaps && (guard % 2) == 0) begin
        wt_valid = 1'b0; wt_data = N'($urandom);
      end else begin
        wt_valid = 1'b1; wt_data = N'(wts[b]); b++;
      end
      tick();
      if (b < KK && (wt_ready !== 1'b1 || conv_rst !== 1'b0)) ok = 0;
    end
    wt_valid = 1'b0;
    chk("load_hold_ready", ok, 1);
    chk("load_cycles", guard, gaps ? 2*KK-1 : KK);
    chk("clear_entry", {wt_ready, conv_rst, conv_ce, act_rd_en}, 4'b0100);
    chk("weight1_loaded", weight1, wexp);
    tick();
    chk("clear_second", {conv_rst, conv_ce, act_rd_en}, 3'b100);
    tick();
    chk("stream_entry", {conv_rst, act_rd_en}, 2'b01);
    // Streaming: address walk, conv_ce/activation one cycle behind the read.
    ok = 1;
    for (int a = 0; a < NN; a++) begin
      if (act_addr !== ADDR_W'(a) || act_rd_en !== 1'b1 || busy !== 1'b1) ok = 0;
      if (conv_ce !== (a > 0)) ok = 0;
      if (a > 0 && conv_activation !== N'(mem[a-1])) ok = 0;
      if (a == rst_at) begin
        chk("stream_seq_pre_rst", ok, 1);
        #1 global_rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {busy, done, err, wt_ready, act_rd_en, conv_ce, out_we, conv_rst}, 8'b00000001);
        chk("rst_addr", {act_addr, out_addr}, 0);
        chk("rst_data", {out_data, conv_activation}, 0);
        chk("rst_weight1", weight1, 0);
        pq.delete();
        rd_pend = 0;
        tick();
        tick();
        global_rst_n = 1'b1;
        tick();
        tick();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle", {busy, conv_rst}, 2'b00);
        return;
      end
      start = (mid_start && a == 7);
      tick();
    end
    start = 1'b0;
    chk("stream_seq", ok, 1);
    chk("drain_entry", {act_rd_en, conv_ce, conv_activation}, {1'b0, 1'b1, N'(mem[NN-1])});
    // Drain until done, bounded well past DRAIN_MAX.
    dcount = 0; ok = 1;
    while (done !== 1'b1 && dcount < 3*DRAIN_MAX) begin
      if (dcount > 0 && (conv_ce !== 1'b1 || act_rd_en !== 1'b0 || conv_activation !== 0)) ok = 0;
      dcount++;
      tick();
    end
    chk("drain_bounded", done, 1);
    chk("drain_flush", ok, 1);
    if (mock_en) chk("done_after_last_we", done_cyc, last_we_cyc + 1);
    else         chk("drain_timeout_len", dcount, DRAIN_MAX);
    chk("done_err", err, !mock_en);
    chk("done_busy", busy, 1);
    if (hold_start) start = 1'b1;
    tick();
    chk("done_single_pulse", {done, busy}, 2'b00);
    chk("err_sticky", err, !mock_en);
    chk("weight1_held", weight1, wexp);
    chk("out_count", cap_addr.size(), mock_en ? OT : 0);
    chk("done_count", done_cnt, 1);
    for (int j = 0; j < cap_addr.size(); j++) begin
      ev = conv_at(wts, mem, (j / OS) * s, (j % OS) * s);
      chk("out_addr", cap_addr[j], j);
      chk("out_data", cap_data[j], ev);
    end
  endtask

  initial begin
    start = 1'b0; wt_valid = 1'b0; wt_data = '0; act_data = '0;
    conv_op = '0; valid_conv = 1'b0; rd_pend = 0; rd_addr_pend = 0;
    mock_on = 1; extra_on = 0; mock_lat = 1;
    global_rst_n = 1'b1;
    #1 global_rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {busy, done, err, wt_ready, act_rd_en, conv_ce, out_we, conv_rst}, 8'b00000001);
    chk("rst_addr", {act_addr, out_addr}, 0);
    chk("rst_data", {out_data, conv_activation, weight1}, 0);
    tick();
    tick();
    chk("rst_conv_rst_held", conv_rst, 1);
    global_rst_n = 1'b1;
    tick();
    chk("idle_after_rst", {busy, conv_rst, wt_ready, act_rd_en, done}, 5'b00000);

    // Weights 1..9 loaded with gaps, random map.
    for (int i = 0; i < KK; i++) wts[i] = i + 1;
    for (int i = 0; i < NN; i++) mem[i] = $urandom_range(16'hffff, 0);
    run_pass(1, 0, 1, -1, 0, 0, 0);

    // All-ones kernel and map in Q12; start held across DONE into IDLE.
    for (int i = 0; i < KK; i++) wts[i] = 4096;
    for (int i = 0; i < NN; i++) mem[i] = 4096;
    run_pass(0, 0, 1, -1, 0, 1, 0);
    chk("ones_out_first", cap_data[0], 16'h9000);
    chk("ones_out_last", cap_data[OT-1], 16'h9000);
    chk("held_start_idle", busy, 0);
    tick();
    start = 1'b0;

    // Identity-centre kernel on a ramp map, pass already started by held start.
    for (int i = 0; i < KK; i++) wts[i] = (i == KK/2) ? 4096 : 0;
    for (int i = 0; i < NN; i++) mem[i] = i;
    run_pass(0, 0, 1, -1, 0, 0, 1);
    for (int j = 0; j < OT; j++) chk("ramp_out", cap_data[j], (j/OS + 1)*n + (j%OS) + 1);

    // Random pass with a start pulse mid-stream and a surplus valid.
    for (int i = 0; i < KK; i++) wts[i] = $urandom_range(16'hffff, 0);
    for (int i = 0; i < NN; i++) mem[i] = $urandom_range(16'hffff, 0);
    run_pass(0, 1, 1, -1, 1, 0, 0);

    // Convolver never answers: drain timeout.
    run_pass(0, 0, 0, -1, 0, 0, 0);

    // Reset mid-stream, then a clean random pass.
    run_pass(0, 0, 1, 12, 0, 0, 0);
    for (int i = 0; i < KK; i++) wts[i] = $urandom_range(16'hffff, 0);
    for (int i = 0; i < NN; i++) mem[i] = $urandom_range(16'hffff, 0);
    run_pass(1, 0, 1, -1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
